shreg_sequencer: RTL

Command sequencer for the team's 4-bit universal shift register (mode `00` hold, `01` shift left, `10` shift right, `11` parallel load).
- Accepts load/shift/read commands over a valid/ready handshake and drives the register's `mode`/`parallel_in` for the required number of cycles.
- Samples the register's `parallel_out` and returns it over a valid/ready response channel.
- Sits between a host/test controller and one `universal_reg` instance, which it owns exclusively.

---
 rtl/shreg_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/shreg_sequencer.sv
// -----------------------------------------------------------------------------
// shreg_sequencer
//
// Command sequencer for a 4-bit universal shift register
// (mode 00 hold, 01 shift left, 10 shift right, 11 parallel load).
//
// The sequencer accepts read / shift-left / shift-right / load commands over a
// valid/ready handshake. It drives the register's mode and parallel_in for the
// required number of cycles, then samples parallel_out and returns it over a
// valid/ready response channel. It owns the register exclusively: outside
// command execution reg_mode is always hold (00).
//
// Optional feature: define SHREG_SEQ_CMDBUF_EN to add a one-entry command
// buffer. A buffered command launches on the response handshake edge with no
// IDLE cycle in between.
//
// Parameters:
//   WIDTH  register data width
//   CNT_W  shift-count width (max count 2^CNT_W-1)
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   cmd_valid/ready    command handshake
//   cmd_op             00 read, 01 shift left, 10 shift right, 11 load
//   cmd_data           load value
//   cmd_count          shift count N
//   reg_mode           registered mode to the shift register
//   reg_parallel_in    registered parallel data to the shift register
//   reg_parallel_out   contents of the shift register
//   rsp_valid/ready    response handshake
//   rsp_data           register contents after the command
//   busy               high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module shreg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       reg_mode,
  output logic [WIDTH-1:0] reg_parallel_in,
  input  logic [WIDTH-1:0] reg_parallel_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b11;
  localparam logic [1:0] MODE_HOLD = 2'b00;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rsp_fire;

  // Command being launched this edge, either straight from the port or from
  // the buffer. take_cmd marks that the port command is consumed directly.
  logic             launch;
  logic             take_cmd;
  logic [1:0]       l_op;
  logic [WIDTH-1:0] l_data;
  logic [CNT_W-1:0] l_cnt;

  assign rsp_fire = rsp_valid & rsp_ready;
  assign busy     = (state != S_IDLE);

`ifdef SHREG_SEQ_CMDBUF_EN
  logic             buf_valid;
  logic [1:0]       buf_op;
  logic [WIDTH-1:0] buf_data;
  logic [CNT_W-1:0] buf_cnt;
  logic             cmd_fire;

  assign cmd_ready = ~buf_valid;
  assign cmd_fire  = cmd_valid & cmd_ready;

  always_comb begin
    launch   = 1'b0;
    take_cmd = 1'b0;
    l_op     = cmd_op;
    l_data   = cmd_data;
    l_cnt    = cmd_count;
    if (state == S_IDLE) begin
      // The buffer is always empty in IDLE, so the port is ready here.
      launch   = cmd_valid;
      take_cmd = cmd_valid;
    end else if (rsp_fire) begin
      if (buf_valid) begin
        launch = 1'b1;
        l_op   = buf_op;
        l_data = buf_data;
        l_cnt  = buf_cnt;
      end else begin
        launch   = cmd_valid;
        take_cmd = cmd_valid;
      end
    end
  end

  // Buffer fills when a command is accepted while the FSM cannot start it,
  // and frees on the edge its command launches. Both cannot coincide because
  // cmd_ready is low while the buffer holds an entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
    end else if (launch && !take_cmd) begin
      buf_valid <= 1'b0;
    end else if (cmd_fire && !take_cmd) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire && !take_cmd) begin
      buf_op   <= cmd_op;
      buf_data <= cmd_data;
      buf_cnt  <= cmd_count;
    end
  end
`else
  assign cmd_ready = (state == S_IDLE);

  always_comb begin
    launch   = 1'b0;
    take_cmd = 1'b0;
    l_op     = cmd_op;
    l_data   = cmd_data;
    l_cnt    = cmd_count;
    if (state == S_IDLE) begin
      launch   = cmd_valid;
      take_cmd = cmd_valid;
    end
  end
`endif

  // reg_mode is registered from the next state so that it equals the command
  // op for exactly the EXEC cycles and is hold everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      reg_mode        <= MODE_HOLD;
      reg_parallel_in <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
    end else begin
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
      if (launch) begin
        if (l_op == OP_LOAD) begin
          state           <= S_EXEC;
          cnt             <= CNT_W'(1);
          reg_mode        <= OP_LOAD;
          reg_parallel_in <= l_data;
        end else if (l_op != OP_READ && l_cnt != '0) begin
          state    <= S_EXEC;
          cnt      <= l_cnt;
          reg_mode <= l_op;
        end else begin
          // Read and zero-length shifts never disturb the register.
          state    <= S_CAPTURE;
          reg_mode <= MODE_HOLD;
        end
      end else begin
        case (state)
          S_EXEC: begin
            if (cnt == CNT_W'(1)) begin
              state    <= S_CAPTURE;
              reg_mode <= MODE_HOLD;
            end
            // Only decremented while >= 1, so no wrap.
            cnt <= cnt - CNT_W'(1);
          end
          S_CAPTURE: begin
            rsp_data  <= reg_parallel_out;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
          S_RESP: begin
            if (rsp_fire) begin
              state <= S_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
